// File: rtl/featuremap_accum.sv
// featuremap_accum: sums NUM_CH conv lanes in a pipelined adder tree, adds bias, saturates, tracks raster and per-frame overflow.
// Optional FEATUREMAP_ACCUM_LEAKY_RELU_EN adds a registered leaky-ReLU stage (slope 0.09375) after saturation.
module featuremap_accum #(
    parameter int NUM_CH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS = 16,
    parameter int IMG_SIZE = 208,
    parameter logic signed [DATA_WIDTH-1:0] BIAS = '0
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         valid_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    output logic                         sof_out,
    output logic                         last_out,
    output logic                         ovf_flag
);
    localparam int S = $clog2(NUM_CH);
    localparam int TW = DATA_WIDTH + S;
    localparam int BW = TW + 1;
    localparam int CW = $clog2(IMG_SIZE + 1);

    if ((1 << S) != NUM_CH || NUM_CH < 2 || FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_cfg
        $error("featuremap_accum: invalid parameter set");
    end

    // Heap-ordered tree: tree[1] is the root, leaves sit at NUM_CH..2*NUM_CH-1.
    logic signed [TW-1:0] tree [1:2*NUM_CH-1];
    logic signed [TW-1:0] node [1:NUM_CH-1];
    logic [S-1:0]         vld;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        assign tree[NUM_CH+k] = {{S{data_in[k*DATA_WIDTH+DATA_WIDTH-1]}}, data_in[k*DATA_WIDTH +: DATA_WIDTH]};
    end
    for (genvar n = 1; n < NUM_CH; n++) begin : g_node
        assign tree[n] = node[n];
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int n = 1; n < NUM_CH; n++) node[n] <= '0;
            vld <= '0;
        end else begin
            for (int n = 1; n < NUM_CH; n++) node[n] <= tree[2*n] + tree[2*n+1];
            vld <= (vld << 1) | S'(valid_in);
        end
    end

    logic signed [BW-1:0] b_sum;
    logic                 b_vld;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            b_sum <= '0;
            b_vld <= 1'b0;
        end else begin
            b_sum <= {tree[1][TW-1], tree[1]} + {{(BW-DATA_WIDTH){BIAS[DATA_WIDTH-1]}}, BIAS};
            b_vld <= vld[S-1];
        end
    end

    // The sum fits DATA_WIDTH only when every bit from DATA_WIDTH-1 upward equals the sign.
    logic [BW-DATA_WIDTH:0] top;
    logic                   hi, lo;
    logic [DATA_WIDTH-1:0]  sat_val;
    assign top = b_sum[BW-1:DATA_WIDTH-1];
    assign hi = !top[BW-DATA_WIDTH] && (|top);
    assign lo = top[BW-DATA_WIDTH] && !(&top);
    assign sat_val = hi ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : lo ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : b_sum[DATA_WIDTH-1:0];

    logic signed [DATA_WIDTH-1:0] q_data;
    logic                         q_vld, q_sat;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            q_data <= '0;
            q_vld  <= 1'b0;
            q_sat  <= 1'b0;
        end else begin
            q_data <= sat_val;
            q_vld  <= b_vld;
            q_sat  <= hi | lo;
        end
    end

    logic out_sat;

`ifdef FEATUREMAP_ACCUM_LEAKY_RELU_EN
    logic signed [DATA_WIDTH-1:0] a_data, neg;
    logic                         a_vld, a_sat;
    assign neg = (q_data >>> 3) - (q_data >>> 5);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            a_data <= '0;
            a_vld  <= 1'b0;
            a_sat  <= 1'b0;
        end else begin
            a_data <= q_data[DATA_WIDTH-1] ? neg : q_data;
            a_vld  <= q_vld;
            a_sat  <= q_sat;
        end
    end

    assign data_out  = a_data;
    assign valid_out = a_vld;
    assign out_sat   = a_sat;
`else
    assign data_out  = q_data;
    assign valid_out = q_vld;
    assign out_sat   = q_sat;
`endif

    logic [CW-1:0] row, col;
    logic          last_col, last_row;
    assign last_col = col == CW'(IMG_SIZE - 1);
    assign last_row = row == CW'(IMG_SIZE - 1);
    assign sof_out  = valid_out && row == '0 && col == '0;
    assign last_out = valid_out && last_col && last_row;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            row      <= '0;
            col      <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (valid_out) begin
                col <= last_col ? '0 : col + CW'(1);
                if (last_col) row <= last_row ? '0 : row + CW'(1);
            end
            if (sof_out) ovf_flag <= out_sat;
            else if (valid_out && out_sat) ovf_flag <= 1'b1;
        end
    end
endmodule

// File: doc/featuremap_accum.md
Name: featuremap_accum

Overview:
- Parametrised successor to the fixed 16-lane layer feature-map blocks.
- Takes NUM_CH per-input-channel 3x3 convolution results arriving in parallel on one wide bus, and sums them in a pipelined adder tree.
- Adds a per-output-channel bias, saturates to DATA_WIDTH, and emits one output-feature-map pixel per valid beat.
- Tracks the pixel raster: flags start and end of frame and raises a sticky saturation flag per frame.

Parameters:
- NUM_CH, 16, input-channel lane count; power of two, >= 2.
- DATA_WIDTH, 32, signed two's-complement fixed-point lane width.
- FRAC_BITS, 16, fractional bits of lanes, bias and output (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
- IMG_SIZE, 208, output feature-map width = height in pixels.
- BIAS, 0, signed DATA_WIDTH bias added once per pixel.

Ports:
- Clk  input  1  clock.
- Rst  input  1  reset, asynchronous, active-low.
- data_in  input  NUM_CH*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- valid_in  input  1  all lanes of data_in valid this cycle.
- data_out  output  DATA_WIDTH  accumulated, biased, saturated pixel.
- valid_out  output  1  data_out valid.
- sof_out  output  1  with valid_out, first pixel of frame (row 0, col 0).
- last_out  output  1  with valid_out, final pixel (row IMG_SIZE-1, col IMG_SIZE-1).
- ovf_flag  output  1  sticky: some pixel of the current frame saturated.

Behaviour:
- Reset (Rst=0, async) clears:
  - all pipeline data and valid registers, row/col counters and ovf_flag;
  - data_out, valid_out, sof_out and last_out to 0.
  - Reset mid-frame discards in-flight pixels; the next accepted pixel is row 0, col 0.
- Pipeline, no backpressure; advances every cycle. Bubbles (valid_in=0) propagate as valid=0.
- Stages:
  - S = log2(NUM_CH) registered adder-tree stages; each stage sums adjacent pairs and widens by 1 bit, with no intermediate truncation.
  - Bias stage: sign-extended BIAS is added to the tree result, widened 1 more bit.
  - Saturation stage: results above 2^(DATA_WIDTH-1)-1 clamp to 0x7F..F; results below -2^(DATA_WIDTH-1) clamp to 0x80..0. A clamp sets sat_hit for that pixel.
  - Output register.
- Latency: valid_in beat at cycle t -> valid_out at t+S+2 (NUM_CH=16: 6 cycles). Throughput 1 pixel/cycle.
- Raster counters advance on each valid_out:
  - col increments 0..IMG_SIZE-1; on wrap col=0 and row increments.
  - After row IMG_SIZE-1 / col IMG_SIZE-1, both return to 0 (next frame).
  - sof_out = valid_out & row==0 & col==0; last_out = valid_out & final position.
- ovf_flag:
  - On a valid_out with sof_out, ovf_flag <= sat_hit (cleared, then possibly re-set by the same pixel).
  - Otherwise ovf_flag <= ovf_flag | (valid_out & sat_hit).
  - Flag from the last pixel remains visible until the next frame's first pixel.
- Simultaneous last_out and sat_hit: flag set in the same cycle last_out is high.
- No input-side frame markers; frame position is derived solely from the valid beat count.

Optional Feature:
- Macro: FEATUREMAP_ACCUM_LEAKY_RELU_EN.
- Defined: one extra registered stage after saturation, so latency becomes S+3.
  - Non-negative values pass unchanged.
  - Negative x outputs (x>>>3) - (x>>>5), arithmetic shifts (slope 0.09375).
  - sat_hit, sof and last are delayed to match.
- Undefined: no activation stage, latency S+2, output is the linear saturated sum.

Test Plan:
- NUM_CH=4, FRAC_BITS=16, BIAS=0, all lanes 0x00010000, single valid_in beat -> data_out=0x00040000, valid_out high exactly 4 cycles later, for one cycle.
- Same config, BIAS=0xFFFF8000, lanes {0x00010000, 0x00020000, 0xFFFF0000, 0} -> data_out=0x00018000.
- All lanes 0x7FFFFFFF, valid -> data_out=0x7FFFFFFF, ovf_flag=1 the cycle after valid_out. Lanes 0x80000000 -> 0x80000000. ovf_flag clears on the next frame's sof pixel if that pixel does not saturate.
- With FEATUREMAP_ACCUM_LEAKY_RELU_EN, lane sum 0xFFFF0000 (-1.0) -> data_out=0xFFFFE800, latency 5. Positive 0x00020000 passes unchanged.
- IMG_SIZE=4, 16 valid beats with random gaps:
  - sof_out on beat 1, last_out on beat 16 only.
  - Beat 17 raises sof_out again.
- Assert Rst low after 7 of 16 beats with pixels in flight -> outputs 0 immediately, no stale valid_out after release; the next beat produces sof_out.
